// File: rtl/operand_stage_if.sv
// Handshake and writeback bundle between the issue source, the operand stage
// and the ALU. The slave modport is the operand stage's view; the master
// modport is the surrounding pipeline's view (instruction source, ALU side,
// writeback source).
interface operand_stage_if;
  logic        INSTR_VALID;
  logic [31:0] INSTRUCTION;
  logic        INSTR_READY;
  logic        OP_VALID;
  logic        OP_READY;
  logic [7:0]  OPERAND1;
  logic [7:0]  OPERAND2;
  logic [2:0]  ALUOP;
  logic [2:0]  DEST;
  logic        WB_VALID;
  logic [2:0]  WB_ADDR;
  logic [7:0]  WB_DATA;
  logic        ILLEGAL;

  modport slave (
    input  INSTR_VALID, INSTRUCTION, OP_READY, WB_VALID, WB_ADDR, WB_DATA,
    output INSTR_READY, OP_VALID, OPERAND1, OPERAND2, ALUOP, DEST, ILLEGAL
  );

  modport master (
    output INSTR_VALID, INSTRUCTION, OP_READY, WB_VALID, WB_ADDR, WB_DATA,
    input  INSTR_READY, OP_VALID, OPERAND1, OPERAND2, ALUOP, DEST, ILLEGAL
  );
endinterface

// File: rtl/operand_stage.sv
// Issue stage in front of the 8-bit ALU: decodes an instruction, reads two
// operands from an 8x8 register file (with same-cycle writeback bypass),
// tracks outstanding destinations in a busy scoreboard and holds the decoded
// op in a single valid/ready slot feeding the ALU.
module operand_stage (
  input  logic CLK,
  input  logic RESET,
  operand_stage_if.slave bus
);

  typedef enum logic [7:0] {
    OPC_LOADI = 8'h00,
    OPC_MOV   = 8'h01,
    OPC_ADD   = 8'h02,
    OPC_SUB   = 8'h03,
    OPC_AND   = 8'h04,
    OPC_OR    = 8'h05
  } opcode_e;

  logic [7:0] r_regs [8];
  logic [7:0] r_busy;
  logic       r_op_valid;
  logic [7:0] r_operand1;
  logic [7:0] r_operand2;
  logic [2:0] r_aluop;
  logic [2:0] r_dest;
  logic       r_illegal;

  opcode_e    w_opcode;
  logic [2:0] w_dest;
  logic [2:0] w_src1;
  logic [2:0] w_src2;
  logic [7:0] w_imm;
  logic [7:0] w_rd1;
  logic [7:0] w_rd2;
  logic [7:0] w_wb_clear;
  logic [7:0] w_busy_eff;
  logic       w_legal;
  logic       w_use1;
  logic       w_use2;
  logic [2:0] w_aluop;
  logic [7:0] w_op1;
  logic [7:0] w_op2;
  logic       w_conflict;
  logic       w_slot_free;
  logic       w_instr_ready;
  logic       w_accept;
  logic       w_unused_bits;

  assign w_opcode      = opcode_e'(bus.INSTRUCTION[31:24]);
  assign w_dest        = bus.INSTRUCTION[18:16];
  assign w_src1        = bus.INSTRUCTION[10:8];
  assign w_src2        = bus.INSTRUCTION[2:0];
  assign w_imm         = bus.INSTRUCTION[7:0];
  assign w_unused_bits = ^{bus.INSTRUCTION[23:19], bus.INSTRUCTION[15:11]};

  // A writeback landing this cycle is forwarded straight into the read.
  assign w_rd1 = (bus.WB_VALID && bus.WB_ADDR == w_src1) ? bus.WB_DATA : r_regs[w_src1];
  assign w_rd2 = (bus.WB_VALID && bus.WB_ADDR == w_src2) ? bus.WB_DATA : r_regs[w_src2];

  // A busy bit being cleared by this cycle's writeback no longer blocks issue.
  assign w_wb_clear = bus.WB_VALID ? (8'b1 << bus.WB_ADDR) : 8'b0;
  assign w_busy_eff = r_busy & ~w_wb_clear;

  // Decode opcode into ALU select, operand values and which sources it reads.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_legal = 1'b1;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_aluop = 3'b000;
    w_op1   = 8'h00;
    w_op2   = 8'h00;
    case (w_opcode)
      OPC_LOADI: w_op2 = w_imm;
      OPC_MOV: begin
        w_use2 = 1'b1;
        w_op2  = w_rd2;
      end
      OPC_ADD: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_aluop = 3'b001;
        w_op1  = w_rd1; w_op2 = w_rd2;
      end
      OPC_SUB: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_aluop = 3'b001;
        w_op1  = w_rd1; w_op2 = ~w_rd2 + 8'd1;
      end
      OPC_AND: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_aluop = 3'b010;
        w_op1  = w_rd1; w_op2 = w_rd2;
      end
      OPC_OR: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_aluop = 3'b011;
        w_op1  = w_rd1; w_op2 = w_rd2;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_conflict = (w_use1 && w_busy_eff[w_src1]) ||
                      (w_use2 && w_busy_eff[w_src2]) ||
                      w_busy_eff[w_dest];
  assign w_slot_free   = !r_op_valid || bus.OP_READY;
  // Illegal opcodes never touch the register file, so hazards cannot block them.
  assign w_instr_ready = w_slot_free && (!w_legal || !w_conflict);
  assign w_accept      = bus.INSTR_VALID && w_instr_ready;

  // Register file writeback and busy scoreboard (issue set wins over clear).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the register file is explicitly cleared on reset because software
      // relies on every register reading zero afterwards.
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
      r_busy <= 8'h00;
    end else begin
      if (bus.WB_VALID) begin
        r_regs[bus.WB_ADDR] <= bus.WB_DATA;
        r_busy[bus.WB_ADDR] <= 1'b0;
      end
      // NOTE: non-blocking assignments; the later write to the same busy bit
      // takes effect, which gives issue priority over writeback.
      if (w_accept && w_legal) r_busy[w_dest] <= 1'b1;
    end
  end

  // Operand slot: load on accept, drain on consume, hold under backpressure.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op_valid <= 1'b0;
      r_operand1 <= 8'h00;
      r_operand2 <= 8'h00;
      r_aluop    <= 3'b000;
      r_dest     <= 3'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_op_valid <= 1'b1;
        r_operand1 <= w_op1;
        r_operand2 <= w_op2;
        r_aluop    <= w_aluop;
        r_dest     <= w_dest;
      end else if (r_op_valid && bus.OP_READY) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign bus.INSTR_READY = w_instr_ready;
  assign bus.OP_VALID    = r_op_valid;
  assign bus.OPERAND1    = r_operand1;
  assign bus.OPERAND2    = r_operand2;
  assign bus.ALUOP       = r_aluop;
  assign bus.DEST        = r_dest;
  assign bus.ILLEGAL     = r_illegal;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed instruction sequences; expected slot
// contents are queued at issue and compared by a monitor when the ALU side
// consumes the slot. Handshake, hazard and reset behaviour checked inline.
module tb_operand_stage;

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [2:0] aluop;
    logic [2:0] dest;
  } slot_t;

  slot_t exp_q[$];

  operand_stage_if bus();

  operand_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, 5'b0, d, 5'b0, s1, 5'b0, s2};
  endfunction

  function automatic logic [31:0] mki(input logic [2:0] d, input logic [7:0] imm);
    return {8'h00, 5'b0, d, 8'h00, imm};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] o1, input logic [7:0] o2,
                      input logic [2:0] a, input logic [2:0] d);
    slot_t s;
    s.op1 = o1; s.op2 = o2; s.aluop = a; s.dest = d;
    exp_q.push_back(s);
  endtask

  // Present an instruction until accepted (bounded), then withdraw it.
  task automatic send(input logic [31:0] instr);
    bit done = 0;
    bus.INSTR_VALID = 1'b1;
    bus.INSTRUCTION = instr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (bus.INSTR_READY) done = 1;
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: instr 0x%08h never accepted", instr);
    end
    bus.INSTR_VALID = 1'b0;
  endtask

  task automatic wb(input logic [2:0] a, input logic [7:0] d);
    bus.WB_VALID = 1'b1; bus.WB_ADDR = a; bus.WB_DATA = d;
    tick();
    bus.WB_VALID = 1'b0;
  endtask

  task automatic ready_at_negedge(input string name, input logic exp);
    @(negedge CLK);
    chk(name, bus.INSTR_READY, exp);
  endtask

  // Monitor: compare each consumed slot against the oldest expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET && bus.OP_VALID && bus.OP_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_slot: got %h with no expectation",
                   {bus.OPERAND1, bus.OPERAND2, bus.ALUOP, bus.DEST});
        end else begin
          slot_t e;
          e = exp_q.pop_front();
          chk("slot", {10'b0, bus.OPERAND1, bus.OPERAND2, bus.ALUOP, bus.DEST}, {10'b0, e});
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    bus.INSTR_VALID = 1'b0; bus.INSTRUCTION = 32'h0; bus.OP_READY = 1'b1;
    bus.WB_VALID = 1'b0; bus.WB_ADDR = 3'd0; bus.WB_DATA = 8'h00;
    tick(); tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_op_valid", bus.OP_VALID, 0);
    chk("rst_operand1", bus.OPERAND1, 0);
    chk("rst_operand2", bus.OPERAND2, 0);
    chk("rst_aluop",    bus.ALUOP, 0);
    chk("rst_dest",     bus.DEST, 0);
    chk("rst_illegal",  bus.ILLEGAL, 0);
    chk("rst_ready",    bus.INSTR_READY, 1);
    tick();

    // loadi R2,0x2A; then mov R1,R2 stalls on busy[2] until WB bypass
    push(8'h00, 8'h2A, 3'b000, 3'd2);
    send(mki(3'd2, 8'h2A));
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mk(8'h01, 3'd1, 3'd0, 3'd2);
    ready_at_negedge("busy_r2_stall_a", 0);
    tick();
    ready_at_negedge("busy_r2_stall_b", 0);
    tick();
    bus.WB_VALID = 1'b1; bus.WB_ADDR = 3'd2; bus.WB_DATA = 8'h2A;
    ready_at_negedge("wb_r2_bypass_ready", 1);
    push(8'h00, 8'h2A, 3'b000, 3'd1);
    tick();
    bus.WB_VALID = 1'b0; bus.INSTR_VALID = 1'b0;

    // stored R2 readback, then preload R1=05, R2=03 and subtract
    push(8'h2A, 8'h2A, 3'b001, 3'd5);
    send(mk(8'h02, 3'd5, 3'd2, 3'd2));
    wb(3'd1, 8'h05);
    push(8'h00, 8'h03, 3'b000, 3'd2);
    send(mki(3'd2, 8'h03));
    wb(3'd2, 8'h03);
    push(8'h05, 8'hFD, 3'b001, 3'd3);
    send(mk(8'h03, 3'd3, 3'd1, 3'd2));
    wb(3'd2, 8'h80);
    push(8'h05, 8'h80, 3'b001, 3'd4);
    send(mk(8'h03, 3'd4, 3'd1, 3'd2));

    // RAW: add R4,R3,R3 stalls until WB 3/0x02 arrives, zero-stall bypass
    wb(3'd4, 8'h11);
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mk(8'h02, 3'd4, 3'd3, 3'd3);
    for (int i = 0; i < 3; i++) begin
      ready_at_negedge("raw_stall_r3", 0);
      tick();
    end
    bus.WB_VALID = 1'b1; bus.WB_ADDR = 3'd3; bus.WB_DATA = 8'h02;
    ready_at_negedge("raw_bypass_ready", 1);
    push(8'h02, 8'h02, 3'b001, 3'd4);
    tick();
    bus.WB_VALID = 1'b0; bus.INSTR_VALID = 1'b0;

    push(8'h05, 8'h80, 3'b010, 3'd6);
    send(mk(8'h04, 3'd6, 3'd1, 3'd2));
    push(8'h05, 8'h80, 3'b011, 3'd7);
    send(mk(8'h05, 3'd7, 3'd1, 3'd2));

    // WAW: loadi R4 waits for R4's writeback
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mki(3'd4, 8'h99);
    ready_at_negedge("waw_stall_r4", 0);
    tick();
    bus.WB_VALID = 1'b1; bus.WB_ADDR = 3'd4; bus.WB_DATA = 8'h55;
    ready_at_negedge("waw_wb_ready", 1);
    push(8'h00, 8'h99, 3'b000, 3'd4);
    tick();
    bus.WB_VALID = 1'b0; bus.INSTR_VALID = 1'b0;
    tick(); tick();

    // Backpressure: slot holds for 3 cycles, next op loads on consume edge
    bus.OP_READY = 1'b0;
    push(8'h00, 8'h10, 3'b000, 3'd0);
    send(mki(3'd0, 8'h10));
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mki(3'd1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_ready",    bus.INSTR_READY, 0);
      chk("bp_op_valid", bus.OP_VALID, 1);
      chk("bp_operand2", bus.OPERAND2, 8'h10);
      chk("bp_dest",     bus.DEST, 0);
      tick();
    end
    bus.OP_READY = 1'b1;
    ready_at_negedge("bp_release_ready", 1);
    push(8'h00, 8'h20, 3'b000, 3'd1);
    tick();

    // Illegal opcode 0x07 (busy sources ignored), accepted as slot drains
    bus.INSTRUCTION = mk(8'h07, 3'd3, 3'd5, 3'd6);
    ready_at_negedge("illegal_ready", 1);
    tick();
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    chk("illegal_pulse",    bus.ILLEGAL, 1);
    chk("illegal_no_slot",  bus.OP_VALID, 0);
    tick();
    @(negedge CLK);
    chk("illegal_one_cycle", bus.ILLEGAL, 0);
    chk("illegal_still_empty", bus.OP_VALID, 0);
    tick();
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mki(3'd3, 8'h44);
    ready_at_negedge("illegal_no_busy", 1);
    push(8'h00, 8'h44, 3'b000, 3'd3);
    tick();
    bus.INSTR_VALID = 1'b0;
    tick();

    // Reset mid-flight with WB to R5 and an instruction offered
    bus.OP_READY = 1'b0;
    send(mki(3'd2, 8'h77));
    RESET = 1'b1;
    bus.WB_VALID = 1'b1; bus.WB_ADDR = 3'd5; bus.WB_DATA = 8'hEE;
    bus.INSTR_VALID = 1'b1; bus.INSTRUCTION = mki(3'd6, 8'h12);
    tick();
    RESET = 1'b0; bus.WB_VALID = 1'b0; bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    chk("midrst_op_valid", bus.OP_VALID, 0);
    chk("midrst_operand2", bus.OPERAND2, 0);
    chk("midrst_dest",     bus.DEST, 0);
    chk("midrst_illegal",  bus.ILLEGAL, 0);
    bus.OP_READY = 1'b1;
    tick();
    push(8'h00, 8'h00, 3'b001, 3'd0);
    send(mk(8'h02, 3'd0, 3'd5, 3'd2));
    push(8'h00, 8'h00, 3'b000, 3'd1);
    send(mk(8'h01, 3'd1, 3'd0, 3'd7));
    tick(); tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
